// File: rtl/tc_pl_spi_master.sv
// Mode-0 SPI initiator for the PL chip-select fan-out bus.
// Define SPI_LSB_FIRST_EN for LSB-first framing on both tx and rx.
module tc_pl_spi_master #(
  parameter int DATA_W  = 24,
  parameter int CLK_DIV = 4,
  parameter int AGP0_25 = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DATA_W-1:0]  tx_data,
  input  logic [AGP0_25-1:0] sel_in,
  output logic               busy,
  output logic               done,
  output logic [DATA_W-1:0]  rx_data,
  output logic [AGP0_25-1:0] chip_sel,
  output logic               spi_CSN,
  output logic               spi_SCLK,
  output logic               spi_MOSI,
  input  logic               spi_MISO
);

  localparam int HC_W = $clog2(CLK_DIV);
  localparam int BC_W = $clog2(DATA_W);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  logic [2:0]        state;
  logic [HC_W-1:0]   hc;
  logic [BC_W-1:0]   bc;
  logic [DATA_W-1:0] tx_sr;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] tx_nxt;
  logic [DATA_W-1:0] rx_nxt;
  logic              hc_end;
  logic              bc_end;

  assign hc_end = (hc == HC_W'(CLK_DIV - 1));
  assign bc_end = (bc == BC_W'(DATA_W - 1));

  // Zeros shift in behind the data, so MOSI idles low after the last bit.
`ifdef SPI_LSB_FIRST_EN
  assign tx_nxt   = {1'b0, tx_sr[DATA_W-1:1]};
  assign rx_nxt   = {spi_MISO, rx_sr[DATA_W-1:1]};
  assign spi_MOSI = tx_sr[0];
`else
  assign tx_nxt   = {tx_sr[DATA_W-2:0], 1'b0};
  assign rx_nxt   = {rx_sr[DATA_W-2:0], spi_MISO};
  assign spi_MOSI = tx_sr[DATA_W-1];
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      hc       <= '0;
      bc       <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      rx_data  <= '0;
      chip_sel <= '0;
      spi_CSN  <= 1'b1;
      spi_SCLK <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            tx_sr    <= tx_data;
            chip_sel <= sel_in;
            busy     <= 1'b1;
            spi_CSN  <= 1'b0;
            hc       <= '0;
            bc       <= '0;
            state    <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (hc_end) begin
            hc    <= '0;
            state <= S_SHIFT;
          end else begin
            hc <= hc + HC_W'(1);
          end
        end
        S_SHIFT: begin
          if (!hc_end) begin
            hc <= hc + HC_W'(1);
          end else begin
            hc <= '0;
            if (!spi_SCLK) begin
              spi_SCLK <= 1'b1;
            end else begin
              spi_SCLK <= 1'b0;
              tx_sr    <= tx_nxt;
              rx_sr    <= rx_nxt;
              if (bc_end) begin
                state <= S_HOLD;
              end else begin
                bc <= bc + BC_W'(1);
              end
            end
          end
        end
        S_HOLD: begin
          if (hc_end) begin
            hc      <= '0;
            spi_CSN <= 1'b1;
            rx_data <= rx_sr;
            done    <= 1'b1;
            state   <= S_GAP;
          end else begin
            hc <= hc + HC_W'(1);
          end
        end
        S_GAP: begin
          if (hc_end) begin
            hc       <= '0;
            busy     <= 1'b0;
            chip_sel <= '0;
            state    <= S_IDLE;
          end else begin
            hc <= hc + HC_W'(1);
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tc_pl_spi_master.sv
// Directed bench for tc_pl_spi_master: loopback, slave model,
// ignored start, mid-frame reset, stuck MISO and back-to-back frames.
module tb_tc_pl_spi_master;

  localparam int DW = 24;
  localparam int CD = 4;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic [SW-1:0] sel_in = '0;
  logic          busy;
  logic          done;
  logic [DW-1:0] rx_data;
  logic [SW-1:0] chip_sel;
  logic          spi_CSN;
  logic          spi_SCLK;
  logic          spi_MOSI;
  logic          spi_MISO;

  int checks = 0;
  int failures = 0;

  tc_pl_spi_master #(.DATA_W(DW), .CLK_DIV(CD), .AGP0_25(SW)) dut (
    .clk(clk), .rst(rst), .start(start), .tx_data(tx_data),
    .sel_in(sel_in), .busy(busy), .done(done), .rx_data(rx_data),
    .chip_sel(chip_sel), .spi_CSN(spi_CSN), .spi_SCLK(spi_SCLK),
    .spi_MOSI(spi_MOSI), .spi_MISO(spi_MISO)
  );

  always #5 clk = ~clk;

  // MISO source: 0 loopback, 1 stuck 0, 2 stuck 1, 3 slave word
  int            mode = 0;
  logic [DW-1:0] slave_word = '0;
  logic [DW-1:0] slave_sr = '0;

  always @(negedge spi_CSN) slave_sr = slave_word;
  always @(negedge spi_SCLK) slave_sr = {slave_sr[DW-2:0], 1'b0};

  always_comb begin
    spi_MISO = 1'b0;
    case (mode)
      0: spi_MISO = spi_MOSI;
      2: spi_MISO = 1'b1;
      3: spi_MISO = slave_sr[DW-1];
      default: spi_MISO = 1'b0;
    endcase
  end

  int            busy_cnt, csn_low, done_cnt, rises;
  int            mosi_bad, sel_bad, run, min_gap;
  logic          seen_low, first_mosi;
  logic [DW-1:0] cap;
  logic [SW-1:0] exp_sel = '0;
  logic          p_sclk = 1'b0, p_csn = 1'b1, p_mosi = 1'b0;

  always @(negedge clk) begin
    if (busy) busy_cnt++;
    if (!spi_CSN) csn_low++;
    if (done) done_cnt++;
    if (spi_SCLK && !p_sclk) begin
      rises++;
      if (rises == 1) first_mosi = spi_MOSI;
`ifdef SPI_LSB_FIRST_EN
      cap = {spi_MOSI, cap[DW-1:1]};
`else
      cap = {cap[DW-2:0], spi_MOSI};
`endif
    end
    if (spi_MOSI !== p_mosi && !(p_sclk && !spi_SCLK)
        && !(p_csn && !spi_CSN)) mosi_bad++;
    if (busy && chip_sel !== exp_sel) sel_bad++;
    if (spi_CSN) begin
      run++;
    end else begin
      if (p_csn && seen_low && run < min_gap) min_gap = run;
      seen_low = 1'b1;
      run = 0;
    end
    p_sclk = spi_SCLK;
    p_csn  = spi_CSN;
    p_mosi = spi_MOSI;
  end

  function automatic logic [DW-1:0] rev(input logic [DW-1:0] v);
    for (int i = 0; i < DW; i++) rev[i] = v[DW-1-i];
  endfunction

  task automatic clear_mon();
    busy_cnt = 0; csn_low = 0; done_cnt = 0; rises = 0;
    mosi_bad = 0; sel_bad = 0; run = 0; min_gap = 1000000;
    seen_low = 1'b0; first_mosi = 1'b0; cap = '0;
  endtask

  task automatic kick(input logic [DW-1:0] tx, input logic [SW-1:0] sel);
    start = 1'b1;
    tx_data = tx;
    sel_in = sel;
    exp_sel = sel;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max, output logic to);
    int n = 0;
    while (busy && n < max) begin
      @(posedge clk); #1;
      n++;
    end
    to = busy;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, spi_SCLK, spi_MOSI} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ctl busy/done/sclk/mosi=%b want 0000",
               {busy, done, spi_SCLK, spi_MOSI});
    end
    checks++;
    if (spi_CSN !== 1'b1) begin
      failures++;
      $display("FAIL reset_csn got %b want 1", spi_CSN);
    end
    checks++;
    if (rx_data !== '0 || chip_sel !== '0) begin
      failures++;
      $display("FAIL reset_data rx=%h sel=%h want 0", rx_data, chip_sel);
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_loopback();
    logic to;
    mode = 0;
    clear_mon();
    kick(24'hA5A5A5, 8'h01);
    wait_idle(1000, to);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (to !== 1'b0) begin
      failures++; $display("FAIL loop_timeout busy=%b want 0", to);
    end
    checks++;
    if (rx_data !== 24'hA5A5A5) begin
      failures++; $display("FAIL loop_rx got %h want a5a5a5", rx_data);
    end
    checks++;
    if (done_cnt !== 1) begin
      failures++; $display("FAIL loop_done got %0d want 1", done_cnt);
    end
    checks++;
    if (busy_cnt !== (2 * DW + 3) * CD) begin
      failures++;
      $display("FAIL loop_busy got %0d want %0d", busy_cnt, (2*DW+3)*CD);
    end
    checks++;
    if (rises !== DW) begin
      failures++; $display("FAIL loop_rises got %0d want %0d", rises, DW);
    end
    checks++;
    if (csn_low !== (2 * DW + 2) * CD) begin
      failures++;
      $display("FAIL loop_csn got %0d want %0d", csn_low, (2*DW+2)*CD);
    end
    checks++;
    if (cap !== 24'hA5A5A5 || mosi_bad !== 0) begin
      failures++;
      $display("FAIL loop_mosi got %h bad=%0d want a5a5a5 bad=0",
               cap, mosi_bad);
    end
  endtask

  task automatic test_select();
    logic to;
    logic [DW-1:0] exp_rx;
`ifdef SPI_LSB_FIRST_EN
    exp_rx = rev(24'h3C0F81);
`else
    exp_rx = 24'h3C0F81;
`endif
    mode = 3;
    slave_word = 24'h3C0F81;
    clear_mon();
    kick(24'h123456, 8'h04);
    wait_idle(1000, to);
    #1;
    checks++;
    if (to !== 1'b0) begin
      failures++; $display("FAIL sel_timeout busy=%b want 0", to);
    end
    checks++;
    if (sel_bad !== 0) begin
      failures++; $display("FAIL sel_hold bad=%0d want 0", sel_bad);
    end
    checks++;
    if (chip_sel !== 8'h00) begin
      failures++; $display("FAIL sel_after got %h want 00", chip_sel);
    end
    checks++;
    if (rx_data !== exp_rx) begin
      failures++; $display("FAIL sel_rx got %h want %h", rx_data, exp_rx);
    end
    checks++;
    if (mosi_bad !== 0 || cap !== 24'h123456) begin
      failures++;
      $display("FAIL sel_mosi got %h bad=%0d want 123456 bad=0",
               cap, mosi_bad);
    end
  endtask

  task automatic test_start_ignored();
    logic to;
    mode = 0;
    clear_mon();
    kick(24'h0F0F33, 8'h02);
    repeat (49) @(posedge clk);
    #1;
    start = 1'b1;
    tx_data = 24'hFFFFFF;
    sel_in = 8'hFF;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(1000, to);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (to !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL ign_busy got %b want 0", busy);
    end
    checks++;
    if (done_cnt !== 1 || rises !== DW) begin
      failures++;
      $display("FAIL ign_count done=%0d rises=%0d want 1 %0d",
               done_cnt, rises, DW);
    end
    checks++;
    if (cap !== 24'h0F0F33 || rx_data !== 24'h0F0F33 || sel_bad !== 0) begin
      failures++;
      $display("FAIL ign_data tx=%h rx=%h selbad=%0d want 0f0f33 0f0f33 0",
               cap, rx_data, sel_bad);
    end
  endtask

  task automatic test_reset_mid();
    logic to;
    mode = 0;
    clear_mon();
    kick(24'hC3C3C3, 8'h08);
    repeat (99) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if ({spi_CSN, spi_SCLK, busy} !== 3'b100 || chip_sel !== '0) begin
      failures++;
      $display("FAIL rmid_out csn/sclk/busy=%b sel=%h want 100 00",
               {spi_CSN, spi_SCLK, busy}, chip_sel);
    end
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if (done_cnt !== 0 || rx_data !== '0) begin
      failures++;
      $display("FAIL rmid_done got %0d rx=%h want 0 0", done_cnt, rx_data);
    end
    clear_mon();
    kick(24'h5A5A5A, 8'h10);
    wait_idle(1000, to);
    #1;
    checks++;
    if (to !== 1'b0 || rx_data !== 24'h5A5A5A || done_cnt !== 1) begin
      failures++;
      $display("FAIL rmid_fresh rx=%h done=%0d want 5a5a5a 1",
               rx_data, done_cnt);
    end
  endtask

  task automatic test_stuck();
    logic to;
    mode = 2;
    kick(24'h000000, 8'h01);
    wait_idle(1000, to);
    #1;
    checks++;
    if (to !== 1'b0 || rx_data !== 24'hFFFFFF) begin
      failures++; $display("FAIL stuck1 got %h want ffffff", rx_data);
    end
    mode = 1;
    kick(24'hFFFFFF, 8'h01);
    wait_idle(1000, to);
    #1;
    checks++;
    if (to !== 1'b0 || rx_data !== 24'h000000) begin
      failures++; $display("FAIL stuck0 got %h want 000000", rx_data);
    end
  endtask

  task automatic test_back_to_back();
    logic to;
    int n = 0;
    mode = 0;
    clear_mon();
    start = 1'b1;
    tx_data = 24'h81C3E7;
    sel_in = 8'h20;
    exp_sel = 8'h20;
    while (done_cnt < 3 && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    start = 1'b0;
    wait_idle(1000, to);
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (to !== 1'b0 || done_cnt !== 3) begin
      failures++; $display("FAIL b2b_frames got %0d want 3", done_cnt);
    end
    checks++;
    if (min_gap < CD || min_gap > 1000) begin
      failures++;
      $display("FAIL b2b_gap got %0d want >= %0d", min_gap, CD);
    end
    checks++;
    if (rx_data !== 24'h81C3E7 || rises !== 3 * DW) begin
      failures++;
      $display("FAIL b2b_data rx=%h rises=%0d want 81c3e7 %0d",
               rx_data, rises, 3 * DW);
    end
  endtask

  task automatic test_first_bit();
    logic to;
    logic exp_first;
`ifdef SPI_LSB_FIRST_EN
    exp_first = 1'b1;
`else
    exp_first = 1'b0;
`endif
    mode = 0;
    clear_mon();
    kick(24'h000001, 8'h40);
    wait_idle(1000, to);
    #1;
    checks++;
    if (to !== 1'b0 || first_mosi !== exp_first) begin
      failures++;
      $display("FAIL first_mosi got %b want %b", first_mosi, exp_first);
    end
    checks++;
    if (rx_data !== 24'h000001 || cap !== 24'h000001) begin
      failures++;
      $display("FAIL first_rx rx=%h tx=%h want 000001", rx_data, cap);
    end
  endtask

  initial begin
    clear_mon();
    test_reset();
    test_loopback();
    test_select();
    test_start_ignored();
    test_reset_mid();
    test_stuck();
    test_back_to_back();
    test_first_bit();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
